// File: rtl/rmii_rate_guard.sv
// RMII rate guard: limits frames per window and dibits per frame, closing the forwarder for a hold-off on violation.
// Build option RATE_GUARD_STICKY_EN: BLOCK latches until a clear_block pulse instead of timing out.
module rmii_rate_guard #(
  parameter int WINDOW_CYCLES = 50000000,
  parameter int MAX_FRAMES    = 1000,
  parameter int MAX_DIBITS    = 6100,
  parameter int BLOCK_CYCLES  = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        crs_dv,
  input  logic        sigdet,
  input  logic        data_capture,
`ifdef RATE_GUARD_STICKY_EN
  input  logic        clear_block,
`endif
  output logic        close_connection,
  output logic        blocked,
  output logic        violation,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int FW = $clog2(MAX_FRAMES + 1);
  localparam int DW = $clog2(MAX_DIBITS + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [FW-1:0] FR_MAX   = FW'(MAX_FRAMES);
  localparam logic [DW-1:0] DIB_MAX  = DW'(MAX_DIBITS);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLOCK} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   win_q, win_d;
  logic [FW-1:0]   fiw_q, fiw_d;
  logic [DW-1:0]   dib_q, dib_d;
  logic            pend_q, pend_d;
  logic            crs_prev, dc_prev;
  logic [15:0]     frame_d, drop_d;
  logic            close_d, viol_d;
  logic            frame_start, frame_end, carrier_rise, wrap;
  logic            block_release, enter_block;

`ifdef RATE_GUARD_STICKY_EN
  assign block_release = clear_block;
`else
  localparam int HW = $clog2(BLOCK_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(BLOCK_CYCLES - 1);
  logic [HW-1:0]   hold_q, hold_d;
  assign block_release = (hold_q == '0);
`endif

  assign frame_start  = data_capture & ~dc_prev;
  assign frame_end    = ~data_capture & dc_prev;
  assign carrier_rise = crs_dv & ~crs_prev;
  assign wrap         = (win_q == WIN_LAST);
  assign blocked      = (state_q == BLOCK);

  always_comb begin
    state_d     = state_q;
    win_d       = wrap ? '0 : win_q + 1'b1;
    fiw_d       = wrap ? '0 : fiw_q;
    dib_d       = dib_q;
    pend_d      = pend_q;
    frame_d     = frame_cnt;
    viol_d      = 1'b0;
    enter_block = 1'b0;
`ifndef RATE_GUARD_STICKY_EN
    hold_d      = hold_q;
`endif

    // A carrier after the quota is spent is a violation; BLOCK waits for any frame in flight.
    if (carrier_rise && fiw_q == FR_MAX && state_q != BLOCK) begin
      viol_d = 1'b1;
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_d) begin
          enter_block = 1'b1;
        end else if (frame_start) begin
          state_d = ACTIVE;
          dib_d   = DW'(1);
          if (fiw_d != FR_MAX) fiw_d = fiw_d + 1'b1;
          if (frame_cnt != 16'hFFFF) frame_d = frame_cnt + 16'd1;
        end
      end
      ACTIVE: begin
        if (data_capture && dib_q == DIB_MAX) begin
          enter_block = 1'b1;
          viol_d      = 1'b1;
        end else begin
          if (data_capture) dib_d = dib_q + 1'b1;
          if (frame_end) begin
            if (pend_d) enter_block = 1'b1;
            else        state_d = IDLE;
          end
        end
      end
      BLOCK: begin
        if (block_release) begin
          state_d = IDLE;
          fiw_d   = '0;
          win_d   = '0;
        end
`ifndef RATE_GUARD_STICKY_EN
        else begin
          hold_d = hold_q - 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (enter_block) begin
      state_d = BLOCK;
      pend_d  = 1'b0;
      dib_d   = '0;
`ifndef RATE_GUARD_STICKY_EN
      hold_d  = HOLD_INIT;
`endif
    end

    // Disable parks the guard; the lifetime counters keep their values.
    if (!enable) begin
      state_d = IDLE;
      win_d   = '0;
      fiw_d   = '0;
      dib_d   = '0;
      pend_d  = 1'b0;
      viol_d  = 1'b0;
      frame_d = frame_cnt;
`ifndef RATE_GUARD_STICKY_EN
      hold_d  = '0;
`endif
    end

    drop_d = drop_cnt;
    if (carrier_rise && close_connection && drop_cnt != 16'hFFFF) drop_d = drop_cnt + 16'd1;

    close_d = (state_d == BLOCK) || (fiw_d >= FR_MAX) || !enable || !sigdet;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      win_q            <= '0;
      fiw_q            <= '0;
      dib_q            <= '0;
      pend_q           <= 1'b0;
      crs_prev         <= 1'b0;
      dc_prev          <= 1'b0;
      frame_cnt        <= '0;
      drop_cnt         <= '0;
      close_connection <= 1'b0;
      violation        <= 1'b0;
`ifndef RATE_GUARD_STICKY_EN
      hold_q           <= '0;
`endif
    end else begin
      state_q          <= state_d;
      win_q            <= win_d;
      fiw_q            <= fiw_d;
      dib_q            <= dib_d;
      pend_q           <= pend_d;
      crs_prev         <= crs_dv;
      dc_prev          <= data_capture;
      frame_cnt        <= frame_d;
      drop_cnt         <= drop_d;
      close_connection <= close_d;
      violation        <= viol_d;
`ifndef RATE_GUARD_STICKY_EN
      hold_q           <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_rmii_rate_guard.sv
// Directed bench for rmii_rate_guard: table-driven rate-limit/violation run plus oversize, enable, reset and sticky sequences.
module tb_rmii_rate_guard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        crs_dv = 1'b0;
  logic        sigdet = 1'b1;
  logic        data_capture = 1'b0;
  logic        close_connection, blocked, violation;
  logic [15:0] frame_cnt, drop_cnt;
`ifdef RATE_GUARD_STICKY_EN
  logic        clear_block = 1'b0;
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rmii_rate_guard #(
    .WINDOW_CYCLES(100),
    .MAX_FRAMES(3),
    .MAX_DIBITS(20),
    .BLOCK_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .crs_dv(crs_dv),
    .sigdet(sigdet),
    .data_capture(data_capture),
`ifdef RATE_GUARD_STICKY_EN
    .clear_block(clear_block),
`endif
    .close_connection(close_connection),
    .blocked(blocked),
    .violation(violation),
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    int          n;
    logic        crs;
    logic        dc;
    logic        clr;
    logic        e_close;
    logic        e_blk;
    logic        e_viol;
    logic [15:0] e_frame;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, logic crs, logic dc, logic clr, logic cl, logic bk,
                              logic vi, logic [15:0] fr, logic [15:0] dr);
    vec_t v;
    v.n = n; v.crs = crs; v.dc = dc; v.clr = clr;
    v.e_close = cl; v.e_blk = bk; v.e_viol = vi; v.e_frame = fr; v.e_drop = dr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic cl, input logic bk, input logic vi,
                         input logic [15:0] fr, input logic [15:0] dr);
    chk({tag, " close"},     {15'd0, close_connection}, {15'd0, cl});
    chk({tag, " blocked"},   {15'd0, blocked},          {15'd0, bk});
    chk({tag, " violation"}, {15'd0, violation},        {15'd0, vi});
    chk({tag, " frame_cnt"}, frame_cnt, fr);
    chk({tag, " drop_cnt"},  drop_cnt, dr);
  endtask

  // Leaves rst_n released on a falling edge; the next rising edge is the first active one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; crs_dv = 1'b0; data_capture = 1'b0; enable = 1'b1; sigdet = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Window 1: three 10-dibit frames, quota closes the path until the wrap at cycle 100.
    tbl.push_back(mk( 2, 0, 0, 0,  0, 0, 0, 16'd0, 16'd0));
    tbl.push_back(mk( 1, 1, 1, 0,  0, 0, 0, 16'd1, 16'd0));
    tbl.push_back(mk( 9, 1, 1, 0,  0, 0, 0, 16'd1, 16'd0));
    tbl.push_back(mk( 1, 0, 0, 0,  0, 0, 0, 16'd1, 16'd0));
    tbl.push_back(mk( 3, 0, 0, 0,  0, 0, 0, 16'd1, 16'd0));
    tbl.push_back(mk(10, 1, 1, 0,  0, 0, 0, 16'd2, 16'd0));
    tbl.push_back(mk( 4, 0, 0, 0,  0, 0, 0, 16'd2, 16'd0));
    tbl.push_back(mk( 1, 1, 1, 0,  1, 0, 0, 16'd3, 16'd0));
    tbl.push_back(mk( 9, 1, 1, 0,  1, 0, 0, 16'd3, 16'd0));
    tbl.push_back(mk( 1, 0, 0, 0,  1, 0, 0, 16'd3, 16'd0));
    tbl.push_back(mk(58, 0, 0, 0,  1, 0, 0, 16'd3, 16'd0));
    tbl.push_back(mk( 1, 0, 0, 0,  0, 0, 0, 16'd3, 16'd0));
    // Window 2: three short frames, then a 4th carrier triggers the rate violation.
    tbl.push_back(mk( 2, 1, 1, 0,  0, 0, 0, 16'd4, 16'd0));
    tbl.push_back(mk( 1, 0, 0, 0,  0, 0, 0, 16'd4, 16'd0));
    tbl.push_back(mk( 2, 1, 1, 0,  0, 0, 0, 16'd5, 16'd0));
    tbl.push_back(mk( 1, 0, 0, 0,  0, 0, 0, 16'd5, 16'd0));
    tbl.push_back(mk( 1, 1, 1, 0,  1, 0, 0, 16'd6, 16'd0));
    tbl.push_back(mk( 1, 1, 1, 0,  1, 0, 0, 16'd6, 16'd0));
    tbl.push_back(mk( 2, 0, 0, 0,  1, 0, 0, 16'd6, 16'd0));
    tbl.push_back(mk( 1, 1, 0, 0,  1, 1, 1, 16'd6, 16'd1));
    tbl.push_back(mk( 1, 0, 0, 0,  1, 1, 0, 16'd6, 16'd1));
    tbl.push_back(mk(48, 0, 0, 0,  1, 1, 0, 16'd6, 16'd1));
    tbl.push_back(mk( 1, 0, 0, STK, 0, 0, 0, 16'd6, 16'd1));
    tbl.push_back(mk( 2, 1, 1, 0,  0, 0, 0, 16'd7, 16'd1));

    // Outputs while held in reset.
    repeat (2) @(negedge clk);
    chk_all("in_reset", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

    do_reset();
    foreach (tbl[k]) begin
      crs_dv = tbl[k].crs;
      data_capture = tbl[k].dc;
`ifdef RATE_GUARD_STICKY_EN
      clear_block = tbl[k].clr;
`endif
      repeat (tbl[k].n) begin
        @(negedge clk);
`ifdef RATE_GUARD_STICKY_EN
        clear_block = 1'b0;
`endif
      end
      chk_all($sformatf("row%0d", k), tbl[k].e_close, tbl[k].e_blk, tbl[k].e_viol,
              tbl[k].e_frame, tbl[k].e_drop);
    end

    // Oversize: 25 dibits, overflow detected on the 21st.
    do_reset();
    crs_dv = 1'b1; data_capture = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      chk($sformatf("ovs c%0d violation", i), {15'd0, violation}, {15'd0, (i == 21)});
      chk($sformatf("ovs c%0d blocked", i), {15'd0, blocked}, {15'd0, (i >= 21)});
      chk($sformatf("ovs c%0d close", i), {15'd0, close_connection}, {15'd0, (i >= 21)});
    end
    crs_dv = 1'b0; data_capture = 1'b0;
    repeat (2) @(negedge clk);
    crs_dv = 1'b1;
    @(negedge clk);
    chk_all("ovs drop", 1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
    // Asynchronous reset mid-BLOCK, between clock edges.
    #2 rst_n = 1'b0;
    #1 chk_all("ovs async_rst", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; crs_dv = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("ovs after_rst", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

    // Enable toggled low for 5 cycles during an active frame.
    do_reset();
    crs_dv = 1'b1; data_capture = 1'b1;
    @(negedge clk);
    chk_all("en frame1", 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk_all("en off", 1'b1, 1'b0, 1'b0, 16'd1, 16'd0);
    crs_dv = 1'b0; data_capture = 1'b0;
    repeat (4) @(negedge clk);
    chk_all("en off_hold", 1'b1, 1'b0, 1'b0, 16'd1, 16'd0);
    enable = 1'b1;
    @(negedge clk);
    chk_all("en on", 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
    crs_dv = 1'b1; data_capture = 1'b1;
    @(negedge clk);
    chk_all("en frame2", 1'b0, 1'b0, 1'b0, 16'd2, 16'd0);
    sigdet = 1'b0;
    @(negedge clk);
    chk("sigdet_low close", {15'd0, close_connection}, 16'd1);
    sigdet = 1'b1;
    // Asynchronous reset mid-frame.
    #2 rst_n = 1'b0;
    #1 chk_all("en async_rst", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; crs_dv = 1'b0; data_capture = 1'b0;

`ifdef RATE_GUARD_STICKY_EN
    // Sticky: BLOCK holds well past the timed hold-off until clear_block.
    do_reset();
    crs_dv = 1'b1; data_capture = 1'b1;
    repeat (25) @(negedge clk);
    crs_dv = 1'b0; data_capture = 1'b0;
    repeat (210) @(negedge clk);
    chk("stk held blocked", {15'd0, blocked}, 16'd1);
    chk("stk held close", {15'd0, close_connection}, 16'd1);
    clear_block = 1'b1;
    @(negedge clk);
    clear_block = 1'b0;
    chk("stk cleared blocked", {15'd0, blocked}, 16'd0);
    chk("stk cleared close", {15'd0, close_connection}, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rmii_rate_guard.md
Name: rmii_rate_guard

Overview:
Policy controller that sequences the RMII forwarding path by driving its close_connection input.
- Monitors crs_dv and the forwarder's data_capture flag.
- Counts frames per time window and dibits per frame.
- On a rate or length violation, closes the connection for a hold-off period.
- Sits beside the RMII forwarder in the 50 MHz RMII clock domain; exposes status counters to the management logic.

Parameters:
WINDOW_CYCLES, 50000000, rate window length in clk cycles (1 s at 50 MHz); must be >= 2
MAX_FRAMES, 1000, maximum frames accepted per window; must be >= 1
MAX_DIBITS, 6100, maximum dibits per frame (1525 bytes x 4)
BLOCK_CYCLES, 5000000, hold-off duration in clk cycles after a violation; must be >= 1

Ports:
clk  in  1  50 MHz RMII reference clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = policing active; 0 = path closed, guard idle
crs_dv  in  1  RMII carrier sense / data valid from PHY
sigdet  in  1  PHY signal detect
data_capture  in  1  forwarder frame-in-progress flag
close_connection  out  1  to forwarder; 1 = refuse new frames
blocked  out  1  1 while in BLOCK state
violation  out  1  single-cycle pulse on each detected violation
frame_cnt  out  16  frames forwarded since reset, saturating
drop_cnt  out  16  frames refused since reset, saturating

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; window, dibit and hold counters 0; prev-value registers for crs_dv and data_capture = 0.
- Edge detection, registered every cycle:
  - frame_start = data_capture & ~dc_prev
  - frame_end = ~data_capture & dc_prev
  - carrier_rise = crs_dv & ~crs_prev
- Window timer:
  - Free-runs 0..WINDOW_CYCLES-1, then wraps to 0.
  - On the wrap cycle, frames_in_window is cleared to 0. A frame_start in that same cycle sets frames_in_window to 1 (the start belongs to the new window).
- State machine:
  - IDLE: close_connection = 0. frame_start -> ACTIVE; frames_in_window+1; frame_cnt+1 (saturate at 0xFFFF); dibit counter loaded with 1.
  - ACTIVE: dibit counter increments each cycle while data_capture = 1.
    - frame_end -> IDLE.
    - Dibit counter reaching MAX_DIBITS+1 -> BLOCK, violation pulse. The forwarder finishes the frame on crs_dv deassert; close prevents the next start.
  - BLOCK: close_connection = 1, blocked = 1. Hold counter loaded with BLOCK_CYCLES-1 on entry and decrements each cycle. At 0: -> IDLE, frames_in_window cleared, window timer restarted at 0.
- Rate limit:
  - When frames_in_window reaches MAX_FRAMES (after counting the MAX-th frame), close_connection is registered to 1 on the next cycle. It stays 1 until the window wraps.
  - This is not a violation and is not BLOCK.
  - carrier_rise while frames_in_window == MAX_FRAMES and not in BLOCK -> violation pulse, state -> BLOCK once any ACTIVE frame ends.
- Drop count: every carrier_rise while close_connection = 1 increments drop_cnt (saturating at 0xFFFF).
- close_connection = BLOCK | (frames_in_window >= MAX_FRAMES) | ~enable | ~sigdet, registered (1-cycle latency from cause).
- enable = 0:
  - Forces state IDLE and clears the window timer, frames_in_window, and the dibit and hold counters.
  - frame_cnt and drop_cnt are held, not cleared.
  - An in-progress frame is not counted further.
- sigdet low mid-frame: no special action; frame_end on the data_capture fall returns to IDLE.
- Simultaneous frame_end and dibit overflow in the same cycle: overflow wins (-> BLOCK).
- Simultaneous window wrap and BLOCK exit: the window restarts at 0 and frames_in_window = 0.
- Reset mid-frame or mid-BLOCK: immediate return to reset values.

Optional Feature:
RATE_GUARD_STICKY_EN
- Defined: BLOCK is latching; the hold counter is unused. An extra input port clear_block (1 bit, active-high pulse) is required to exit BLOCK -> IDLE, with the same clears as the timed exit. clear_block in any other state is ignored.
- Undefined: no clear_block port; timed release after BLOCK_CYCLES as above.

Test Plan:
Parameters for all scenarios: WINDOW_CYCLES=100, MAX_FRAMES=3, MAX_DIBITS=20, BLOCK_CYCLES=50, enable=1, sigdet=1.
- Reset: assert rst_n=0 mid-frame -> all outputs 0 within the same cycle; after release, close_connection=0.
- Rate limit: 3 frames of 10 dibits in one window -> frame_cnt=3, close_connection=1 one cycle after the 3rd frame_start. It stays 1 until the window wrap at cycle 100, then returns to 0. drop_cnt=0.
- Rate violation: 4th crs_dv rise inside that window -> violation pulse for 1 cycle, drop_cnt=1, blocked=1 for 50 cycles, then close_connection=0 and frames_in_window=0.
- Oversize frame: one frame with data_capture high 25 cycles -> violation on the 21st dibit, blocked=1, frame_cnt=1. Next crs_dv rise during BLOCK -> drop_cnt=1.
- Enable toggle: enable=0 for 5 cycles during ACTIVE -> close_connection=1 one cycle later. frame_cnt unchanged; after enable=1, state IDLE and the next frame is accepted.
- Sticky build (RATE_GUARD_STICKY_EN): after an oversize violation, blocked stays 1 for over 200 cycles; a clear_block pulse -> blocked=0 and close_connection=0 next cycle.
